lsu_mem_if: RTL
===============

Name: lsu_mem_if

Overview:
Load/store unit between the pipeline MEM stage and the single-port data RAM.
- Accepts one load or store request per handshake.
- Generates RAM chip-enable, byte-select, address and aligned write data.
- Extracts and sign/zero-extends read data.
- Reports misaligned and out-of-range accesses as precise exceptions.
- Returns a registered response through a valid/ready handshake so MEM can stall.

Parameters:
WIDTH, 32, data/address width (only 32 supported)
RAM_DEPTH, 2048, RAM words; legal byte addresses are 0 to RAM_DEPTH*4-1

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  MEM-stage request present
req_ready  output  1  request accepted this cycle when high with req_valid
req_we  input  1  1=store, 0=load
req_funct3  input  3  RV32 width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  WIDTH  byte address
req_wdata  input  WIDTH  store data, LSB-aligned
flush  input  1  kill pending response (trap/redirect)
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed
rsp_rdata  output  WIDTH  extended load data (0 for stores/exceptions)
rsp_exc  output  1  exception flag
rsp_cause  output  4  mcause code: 4 load-misaligned, 5 load-fault, 6 store-misaligned, 7 store-fault
rsp_badaddr  output  WIDTH  faulting address (mtval)
ram_ce, ram_we  output  1 each  RAM enable / write enable
ram_sel  output  4  byte enables
ram_addr  output  WIDTH  RAM byte address (= req_addr)
ram_data_in  output  WIDTH  lane-replicated store data
ram_rvalid  input  1  RAM read-valid
ram_data  input  WIDTH  RAM combinational read data

Behaviour:
- Clock clk; reset rst_n is asynchronous, active-low. Reset: state IDLE, rsp_valid=0, rsp_rdata=0, rsp_exc=0, rsp_cause=0, rsp_badaddr=0.
- FSM states:
  - IDLE: req_ready=1; accept moves to RESP.
  - RESP: rsp_valid=1. If rsp_ready, req_ready=1; a simultaneous accept stays in RESP with new response, else go to IDLE. If !rsp_ready, req_ready=0 and all rsp_* hold.
- flush forces req_ready=0, next state IDLE, rsp_valid=0 next cycle. No RAM access in a flush cycle. Flush has priority over every other event.
- Accept cycle = req_valid & req_ready. RAM is driven only in the accept cycle and only when the access is fault-free; otherwise ram_ce=0 and ram_sel=0.
- Misaligned check:
  - H/HU with addr[0]=1 is misaligned.
  - W with addr[1:0]!=0 is misaligned.
  - Misaligned takes priority over range fault.
- Range fault: req_addr >= RAM_DEPTH*4.
- ram_sel:
  - B: 4'b0001<<addr[1:0].
  - H: 0011 if addr[1]=0, else 1100.
  - W: 1111.
- ram_data_in: byte replicated to all 4 lanes; half replicated to both halves; word unchanged.
- Loads: ram_we=0; ram_data sampled in the accept cycle (ram_rvalid must be 1). Selected lane is sign-extended (B/H) or zero-extended (BU/HU) into rsp_rdata. Latency: response valid 1 cycle after accept.
- Stores: ram_we=1; write occurs at the accept clock edge; response with rsp_rdata=0 follows 1 cycle later.
- Exceptions: rsp_exc=1, cause per the table above, rsp_badaddr=req_addr, rsp_rdata=0. RAM is untouched.
- Unsupported funct3 (load 011/110/111, store >=011): no RAM access, response with rsp_exc=0 and rsp_rdata=0.
- Reset mid-response discards the response. Any RAM write at an already-taken clock edge stands.

Decomposition:
- Shared package/header: funct3 width codes, mcause codes 4–7, FSM state encodings.
- One sub-module, lsu_align: combinational byte-enable/lane-replication generator and load extract/extend logic.
- lsu_mem_if holds the FSM, fault checks and response registers.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> ram_sel=1111; next-cycle rsp_rdata=0xDEADBEEF, rsp_exc=0.
- SB 0x13 data 0x000000A5, then LB 0x13 and LBU 0x13 -> ram_sel=1000, ram_data_in=0xA5A5A5A5; rsp_rdata=0xFFFFFFA5 and 0x000000A5.
- LH 0x11 -> no ram_ce; rsp_exc=1, rsp_cause=4, rsp_badaddr=0x11. SW 0x2000 (DEPTH 2048) -> rsp_cause=7, RAM unchanged.
- Back-to-back LW 0x0, 0x4 with rsp_ready=1 -> one accept per cycle; two consecutive responses in order.
- rsp_ready=0 for 3 cycles during a response -> req_ready=0; rsp_* stable; new request accepted the cycle rsp_ready rises.
- flush while RESP and req_valid=1 -> rsp_valid=0 next cycle, request not accepted, ram_ce=0. Assert rst_n low mid-RESP -> outputs 0 immediately.

Source files
------------

// File: rtl/lsu_mem_if_pkg.sv
// Shared definitions for the load/store unit:
// funct3 width codes, trap causes, FSM states, response bundle.
package lsu_mem_if_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] CAUSE_LD_MIS = 4'd4;
  localparam logic [3:0] CAUSE_LD_FLT = 4'd5;
  localparam logic [3:0] CAUSE_ST_MIS = 4'd6;
  localparam logic [3:0] CAUSE_ST_FLT = 4'd7;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic        exc;
    logic [3:0]  cause;
    logic [31:0] badaddr;
  } rsp_t;

endpackage

// File: rtl/lsu_mem_if_if.sv
// MEM-stage <-> LSU request/response handshake bundle.
// master = pipeline side, slave = LSU side.
interface lsu_mem_if_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [2:0]       req_funct3;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             flush;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_rdata;
  logic             rsp_exc;
  logic [3:0]       rsp_cause;
  logic [WIDTH-1:0] rsp_badaddr;

  modport master (
    output req_valid, req_we, req_funct3,
    output req_addr, req_wdata, flush,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_exc, rsp_cause, rsp_badaddr
  );

  modport slave (
    input  req_valid, req_we, req_funct3,
    input  req_addr, req_wdata, flush,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_exc, rsp_cause, rsp_badaddr
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-enable / store lane replication and
// load lane extract with sign or zero extension.
module lsu_align
  import lsu_mem_if_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic       is_b;
  logic       is_h;
  logic       is_w;
  logic       uns;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign is_b = funct3[1:0] == 2'b00;
  assign is_h = funct3[1:0] == 2'b01;
  assign is_w = funct3[1:0] == 2'b10;
  assign uns  = funct3[2];

  always_comb begin
    byte_v = rdata[7:0];
    unique case (addr_lo)
      2'd0: byte_v = rdata[7:0];
      2'd1: byte_v = rdata[15:8];
      2'd2: byte_v = rdata[23:16];
      2'd3: byte_v = rdata[31:24];
    endcase
    half_v = addr_lo[1] ? rdata[31:16]
                        : rdata[15:0];
  end

  always_comb begin
    sel       = 4'b0000;
    wdata_rep = wdata;
    rdata_ext = '0;
    unique case (1'b1)
      is_b: begin
        sel       = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{~uns & byte_v[7]}},
                     byte_v};
      end
      is_h: begin
        sel       = addr_lo[1] ? 4'b1100
                               : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{~uns & half_v[15]}},
                     half_v};
      end
      is_w: begin
        sel       = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
      end
      default: begin
        sel       = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = '0;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit: request FSM, alignment and
// range checks, registered response to MEM stage.
module lsu_mem_if
  import lsu_mem_if_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int RAM_DEPTH = 2048
) (
  input  logic             clk,
  input  logic             rst_n,
  lsu_mem_if_if.slave      bus,
  output logic             ram_ce,
  output logic             ram_we,
  output logic [3:0]       ram_sel,
  output logic [WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0] ram_data_in,
  input  logic             ram_rvalid,
  input  logic [WIDTH-1:0] ram_data
);

  localparam logic [WIDTH:0] LIMIT =
    (WIDTH+1)'(RAM_DEPTH * 4);

  state_e state_q, state_d;
  rsp_t   rsp_q, rsp_d, rsp_new;

  logic        req_ready;
  logic        accept;
  logic        supported;
  logic        misal;
  logic        oor;
  logic        ram_go;
  logic [2:0]  f3;
  logic [WIDTH-1:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata_rep;
  logic [31:0] rdata_ext;

  assign f3   = bus.req_funct3;
  assign addr = bus.req_addr;

  lsu_align u_align (
    .funct3    (f3),
    .addr_lo   (addr[1:0]),
    .wdata     (bus.req_wdata),
    .rdata     (ram_data),
    .sel       (sel),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext)
  );

  always_comb begin
    if (bus.req_we)
      supported = f3 inside {F3_B, F3_H, F3_W};
    else
      supported = f3 inside {F3_B, F3_H, F3_W,
                             F3_BU, F3_HU};
    misal = (f3[1:0] == 2'b01 && addr[0]) ||
            (f3[1:0] == 2'b10 &&
             addr[1:0] != 2'b00);
    oor    = {1'b0, addr} >= LIMIT;
    ram_go = supported & ~misal & ~oor;
  end

  // Misalignment outranks range fault; unsupported
  // widths return a clean, empty response.
  always_comb begin
    rsp_new = '0;
    if (supported) begin
      if (misal) begin
        rsp_new.exc     = 1'b1;
        rsp_new.cause   = bus.req_we ? CAUSE_ST_MIS
                                     : CAUSE_LD_MIS;
        rsp_new.badaddr = addr;
      end else if (oor) begin
        rsp_new.exc     = 1'b1;
        rsp_new.cause   = bus.req_we ? CAUSE_ST_FLT
                                     : CAUSE_LD_FLT;
        rsp_new.badaddr = addr;
      end else if (!bus.req_we && ram_rvalid) begin
        rsp_new.rdata = rdata_ext;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rsp_d     = rsp_q;
    req_ready = 1'b0;
    unique case (state_q)
      IDLE: req_ready = 1'b1;
      RESP: req_ready = bus.rsp_ready;
    endcase
    if (bus.flush) req_ready = 1'b0;
    accept = bus.req_valid & req_ready;
    if (bus.flush) begin
      state_d = IDLE;
    end else if (accept) begin
      state_d = RESP;
      rsp_d   = rsp_new;
    end else if (state_q == RESP &&
                 bus.rsp_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      rsp_q   <= rsp_d;
    end
  end

  assign ram_ce      = accept & ram_go;
  assign ram_we      = ram_ce & bus.req_we;
  assign ram_sel     = ram_ce ? sel : 4'b0000;
  assign ram_addr    = addr;
  assign ram_data_in = wdata_rep;

  assign bus.req_ready   = req_ready;
  assign bus.rsp_valid   = state_q == RESP;
  assign bus.rsp_rdata   = rsp_q.rdata;
  assign bus.rsp_exc     = rsp_q.exc;
  assign bus.rsp_cause   = rsp_q.cause;
  assign bus.rsp_badaddr = rsp_q.badaddr;

endmodule
